// File: rtl/ram8.sv
// Eight-word register file: one-hot write demux, asynchronous active-low clear,
// and a zero-latency combinational read mux with no write-to-read bypass.
module ram8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic [WIDTH-1:0] r_word [DEPTH];
  logic [DEPTH-1:0] w_word_en;
  logic [WIDTH-1:0] w_rd_data;

  // Load demux: an X on load yields an X enable, which the if below treats as no write
  always_comb begin
    w_word_en = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_word_en[k] = load & (address == AW'(k));
    end
  end

  // Storage words, each with its own enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_word[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_word_en[k]) begin
          r_word[k] <= in;
        end
      end
    end
  end

  // Read mux: shows the stored word, so a pending write is visible only after its edge
  always_comb begin
    w_rd_data = '0;
    case (address)
      3'd0: w_rd_data = r_word[0];
      3'd1: w_rd_data = r_word[1];
      3'd2: w_rd_data = r_word[2];
      3'd3: w_rd_data = r_word[3];
      3'd4: w_rd_data = r_word[4];
      3'd5: w_rd_data = r_word[5];
      3'd6: w_rd_data = r_word[6];
      3'd7: w_rd_data = r_word[7];
      default: w_rd_data = '0;
    endcase
  end

  assign out = w_rd_data;

endmodule

// File: tb/tb_ram8.sv
// Bench for ram8: an array model checked on every falling edge, plus directed
// scenarios with hand-computed literal expectations.
module tb_ram8;

  localparam int unsigned WIDTH = 16;

  logic             clock;
  logic             reset_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic [WIDTH-1:0] out;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          checking    = 1'b0;

  logic [WIDTH-1:0] model [8];
  logic [WIDTH-1:0] exp_tbl [8];

  ram8 #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: clear on reset, store on a loaded edge
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) model[k] <= '0;
    end else if (load === 1'b1) begin
      model[address] <= in;
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t addr=%0d got=%h expected=%h", name, $time, address, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (checking) check("model", out, reset_n ? model[address] : '0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] exp, input string name);
    address = a;
    #1;
    check(name, out, exp);
  endtask

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    in      = '0;
    address = '0;
    #2 reset_n = 1'b0;
    checking = 1'b1;

    // Writes during reset are ignored and every address reads 0
    tick();
    address = 3'd4; in = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "in_reset");

    @(negedge clock);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "reset_sweep");

    // First edge after release takes the write
    wr(3'd4, 16'h4444);
    rd(3'd4, 16'h4444, "first_write");

    // Write all then read back
    for (int k = 0; k < 7; k++) wr(3'(k), WIDTH'(16'h1111 * (k + 1)));
    wr(3'd7, 16'hFFFF);
    rd(3'd0, 16'h1111, "wall_0");
    rd(3'd6, 16'h7777, "wall_6");
    rd(3'd7, 16'hFFFF, "wall_7");
    for (int k = 0; k < 7; k++) rd(3'(k), WIDTH'(16'h1111 * (k + 1)), "wall_sweep");

    // Read during write: old value until the edge
    wr(3'd3, 16'hAAAA);
    address = 3'd3; in = 16'h5555; load = 1'b1;
    #1 check("rdw_before", out, 16'hAAAA);
    tick();
    load = 1'b0;
    check("rdw_after", out, 16'h5555);

    // Hold for 4 edges with garbage on in
    wr(3'd5, 16'h1234);
    address = 3'd5; in = 16'hDEAD; load = 1'b0;
    repeat (4) begin
      tick();
      check("hold", out, 16'h1234);
    end
    exp_tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h5555,
                16'h5555, 16'h1234, 16'h7777, 16'hFFFF};
    for (int k = 0; k < 8; k++) rd(3'(k), exp_tbl[k], "hold_sweep");

    // Back-to-back same address keeps the last write
    wr(3'd6, 16'h0101);
    wr(3'd6, 16'h0202);
    rd(3'd6, 16'h0202, "b2b_same");

    // Boundary addresses on consecutive edges
    wr(3'd7, 16'h8001);
    wr(3'd0, 16'h0001);
    rd(3'd7, 16'h8001, "bound_7");
    rd(3'd0, 16'h0001, "bound_0");
    rd(3'd6, 16'h0202, "bound_6");

    // Async reset in the middle of a write cycle
    address = 3'd2; in = 16'hBEEF; load = 1'b1;
    #1 check("pre_reset", out, 16'h3333);
    #1 reset_n = 1'b0;
    #1 check("reset_async", out, 16'h0000);
    tick();
    load = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "post_reset");
    wr(3'd2, 16'hBEEF);
    rd(3'd2, 16'hBEEF, "rewrite_2");

    tick();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
- REQ-001: Parameter WIDTH, default 16; data word width in bits; all data ports and storage words SHALL be WIDTH bits.
- REQ-002: Port clock, input, 1; the single clock, and all state SHALL update on its rising edge only.
- REQ-003: Port reset_n, input, 1; asynchronous active-low reset.
- REQ-004: Port in, input, WIDTH; write data.
- REQ-005: Port load, input, 1; write enable, active-high.
- REQ-006: Port address, input, 3; word select, 0..7.
- REQ-007: Port out, output, WIDTH; read data for the word selected by address.

Function
- REQ-008: Storage SHALL be 8 words of WIDTH bits, reg0..reg7, each a clocked register with its own load enable.
- REQ-009: The address SHALL be decoded into eight one-hot word enables by an 8-way demux of load: enable k = load AND (address == k).
- REQ-010: On a rising clock edge with reset_n high and load=1, reg[address] SHALL take the value of in.
- REQ-011: On a rising clock edge with load=1, all words other than reg[address] SHALL hold.
- REQ-012: On a rising clock edge with load=0, all eight words SHALL hold.
- REQ-013: out SHALL equal reg[address] combinationally, selected through an 8-way WIDTH-bit mux, with zero cycles of read latency.
- REQ-014: During a write cycle, out SHALL show the old contents of reg[address] until the edge.
- REQ-015: After the write edge, out SHALL show the written value, with no bypass from in to out.
- REQ-016: A change of address with no clock edge SHALL change out within the same cycle; storage SHALL not change.
- REQ-017: Back-to-back writes to the same address on consecutive edges SHALL leave the value of the last write.
- REQ-018: Back-to-back writes to different addresses on consecutive edges SHALL each land in their own word.
- REQ-019: Address values 0 and 7 SHALL behave the same as interior addresses, with no wrap, alias or out-of-range case.
- REQ-020: An X or Z on load SHALL not be treated as a write in simulation; benches SHALL drive load to 0 or 1 at all times.

Reset
- REQ-021: When reset_n goes low, all eight words SHALL clear to 0 immediately, independent of clock.
- REQ-022: While reset_n is low, out SHALL read 0 for every address.
- REQ-023: While reset_n is low, writes SHALL be ignored whatever the value of load.
- REQ-024: If reset is asserted in the middle of a write cycle, the write SHALL be discarded and the word SHALL read 0 after reset.
- REQ-025: The first write SHALL take effect on the first rising edge after reset_n deasserts, provided load=1 at that edge.
- REQ-026: Reset deassertion SHALL itself modify no storage.

Verification
- REQ-027: Reset scenario: pulse reset_n low, then sweep address 0..7 with load=0 -> out=0x0000 at every address.
- REQ-028: Write/read-all scenario: write in=0x1111*(k+1) to address k for k=0..6 and in=0xFFFF to address 7, then read back 0..7 -> each word returns its own value (0x1111 at 0, 0x7777 at 6, 0xFFFF at 7) and no other word is disturbed.
- REQ-029: Read-during-write scenario:
  - preload address 3 with 0xAAAA;
  - drive address=3, in=0x5555, load=1;
  - before the edge out=0xAAAA; after the edge out=0x5555.
- REQ-030: Hold scenario:
  - with address 5 holding 0x1234, drive load=0 and in=0xDEAD for 4 edges -> out stays 0x1234;
  - then sweep the address -> all other words are unchanged.
- REQ-031: Async reset mid-write scenario:
  - fill all eight words with nonzero values;
  - drive load=1, address=2, in=0xBEEF, and drop reset_n between clock edges;
  - out SHALL become 0x0000 before the next edge;
  - after release all words read 0x0000, including address 2.
- REQ-032: Boundary scenario: write 0x8001 to address 7 and then 0x0001 to address 0 on consecutive edges -> address 7 reads 0x8001 and address 0 reads 0x0001, with no aliasing.
